// File: rtl/ultrasonic_scan_ctrl.sv
// ultrasonic_scan_ctrl
// Round-robin ranging engine for up to four ultrasonic sensors. One channel is
// fired at a time: trig pulse, wait for echo rise, time the echo high period,
// convert to cm, report, then hold off before moving to the next channel.
//
// Result handshake: dist_valid is a one-cycle strobe with no ready/backpressure.
// dist_data, dist_chan and dist_timeout are valid in the strobe cycle and hold
// their value until the next strobe, so a slow consumer may also sample them
// later. There is exactly one strobe per fired channel.
module ultrasonic_scan_ctrl #(
  parameter int N_SENSORS      = 4,
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int GAP_CYCLES     = 3000000,
  parameter int DIST_W         = 9
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trig,
  output logic [DIST_W-1:0]    dist_data,
  output logic [1:0]           dist_chan,
  output logic                 dist_valid,
  output logic                 dist_timeout,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  // One shared counter covers trig width, wait/measure timeout and holdoff.
  localparam int CNT_MAX0 = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > TRIG_CYCLES) ? CNT_MAX0 : TRIG_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int SUB_W    = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

  localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_MAX    = DIST_W'((1 << DIST_W) - 2);
  localparam logic [1:0]        CHAN_LAST = 2'(N_SENSORS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    REPORT    = 3'd4,
    HOLDOFF   = 3'd5
  } state_t;

  state_t               state;
  logic [1:0]           chan;
  logic [CNT_W-1:0]     cnt;
  logic [SUB_W-1:0]     sub;
  logic [DIST_W-1:0]    cm;
  logic [N_SENSORS-1:0] echo_m;
  logic [N_SENSORS-1:0] es;
  logic [N_SENSORS-1:0] es_d;
  logic                 es_cur;
  logic                 es_prev;
  logic                 rise;
  logic                 fall;
  logic [1:0]           chan_next;

  function automatic logic [N_SENSORS-1:0] onehot(input logic [1:0] c);
    logic [N_SENSORS-1:0] r;
    r = '0;
    for (int i = 0; i < N_SENSORS; i++) r[i] = (c == 2'(i));
    return r;
  endfunction

  // Two-flop synchronizer on the raw echoes, plus a delayed copy for edges.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      echo_m <= '0;
      es     <= '0;
      es_d   <= '0;
    end else begin
      echo_m <= echo;
      es     <= echo_m;
      es_d   <= es;
    end
  end

  // Only the active channel's synchronized echo is ever looked at; edges are
  // taken against its previous value, so a level already high is not a rise.
  assign es_cur    = es[chan];
  assign es_prev   = es_d[chan];
  assign rise      = es_cur & ~es_prev;
  assign fall      = ~es_cur & es_prev;
  assign chan_next = (chan == CHAN_LAST) ? 2'd0 : chan + 2'd1;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Scan sequencer: trig, wait for echo, measure, report, holdoff, next channel.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      chan         <= 2'd0;
      cnt          <= '0;
      sub          <= '0;
      cm           <= '0;
      trig         <= '0;
      dist_data    <= '0;
      dist_chan    <= 2'd0;
      dist_valid   <= 1'b0;
      dist_timeout <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= TRIG;
            cnt   <= '0;
            sub   <= '0;
            cm    <= '0;
            trig  <= onehot(chan);
          end
        end
        TRIG: begin
          if (cnt == TRIG_LAST) begin
            trig  <= '0;
            cnt   <= '0;
            state <= WAIT_RISE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            // The edge cycle is the first counted echo-high cycle.
            state <= MEASURE;
            cnt   <= CNT_W'(1);
            if (CYCLES_PER_CM == 1) begin
              sub <= '0;
              cm  <= DIST_W'(1);
            end else begin
              sub <= SUB_W'(1);
            end
          end else if (cnt == TO_LAST) begin
            state        <= REPORT;
            dist_valid   <= 1'b1;
            dist_chan    <= chan;
            dist_data    <= '1;
            dist_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MEASURE: begin
          // A falling edge takes priority over a coincident timeout.
          if (fall) begin
            state        <= REPORT;
            dist_valid   <= 1'b1;
            dist_chan    <= chan;
            dist_data    <= cm;
            dist_timeout <= 1'b0;
          end else if (cnt == TO_LAST) begin
            state        <= REPORT;
            dist_valid   <= 1'b1;
            dist_chan    <= chan;
            dist_data    <= '1;
            dist_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (sub == SUB_LAST) begin
              sub <= '0;
              if (cm != CM_MAX) cm <= cm + DIST_W'(1);
            end else begin
              sub <= sub + SUB_W'(1);
            end
          end
        end
        REPORT: begin
          state <= HOLDOFF;
          cnt   <= '0;
        end
        HOLDOFF: begin
          if (cnt == GAP_LAST) begin
            cnt  <= '0;
            chan <= chan_next;
            if (enable) begin
              state <= TRIG;
              sub   <= '0;
              cm    <= '0;
              trig  <= onehot(chan_next);
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          trig  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// tb_ultrasonic_scan_ctrl
// Directed bench for the scan controller with small timing parameters.
// Driver tasks fire pings and push the hand-computed result into exp_q; a
// monitor pops and compares on every dist_valid strobe.
module tb_ultrasonic_scan_ctrl;

  localparam int N    = 4;
  localparam int TRIG = 4;
  localparam int CPC  = 10;
  localparam int TO   = 200;
  localparam int GAP  = 20;
  localparam int DW   = 9;
  // Report cycle, GAP holdoff cycles, then trig is visible one cycle later.
  localparam int REPORT_TO_TRIG = GAP + 1;
  localparam logic [DW-1:0] ALL1 = 9'h1FF;

  logic          clock;
  logic          resetn;
  logic          enable;
  logic [N-1:0]  echo;
  logic [N-1:0]  trig;
  logic [DW-1:0] dist_data;
  logic [1:0]    dist_chan;
  logic          dist_valid;
  logic          dist_timeout;
  logic          busy;
  logic [2:0]    state_dbg;

  logic [11:0]   exp_q[$];
  logic [11:0]   exp_item;
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            last_valid_cyc = -1;
  int            onehot_bad = 0;

  ultrasonic_scan_ctrl #(
    .N_SENSORS(N), .TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPC),
    .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .DIST_W(DW)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .echo(echo),
    .trig(trig), .dist_data(dist_data), .dist_chan(dist_chan),
    .dist_valid(dist_valid), .dist_timeout(dist_timeout), .busy(busy),
    .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (resetn && dist_valid) begin
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: chan=%0d data=%0d timeout=%0d with empty queue",
                 dist_chan, dist_data, dist_timeout);
      end else begin
        exp_item = exp_q.pop_front();
        check("result_chan", int'(dist_chan), int'(exp_item[11:10]));
        check("result_timeout", int'(dist_timeout), int'(exp_item[9]));
        check("result_data", int'(dist_data), int'(exp_item[8:0]));
      end
    end
  end

  // At most one trig bit may be high at any time.
  always @(negedge clock) begin
    if ($countones(trig) > 1) onehot_bad++;
  end

  // Wait for trig[c] to rise, then measure how many cycles it stays high.
  task automatic wait_trig(input int c, output int width, output bit ok, output int tcyc);
    width = 0;
    ok    = 1'b0;
    tcyc  = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (trig[c]) break;
    end
    if (!trig[c]) begin
      checks++;
      errors++;
      $display("FAIL trig_wait: trig[%0d] never rose, got 0, expected 1", c);
      return;
    end
    ok   = 1'b1;
    tcyc = cyc;
    check("busy_during_trig", int'(busy), 1);
    while (trig[c] && width < 100) begin
      width++;
      @(negedge clock);
    end
  endtask

  task automatic echo_pulse(input int c, input int len);
    repeat (2) @(negedge clock);
    echo[c] = 1'b1;
    repeat (len) @(negedge clock);
    echo[c] = 1'b0;
  endtask

  // One ping on channel c: echo high for len cycles (0 = no echo).
  task automatic ping(input int c, input int len, input int exp_data, input bit exp_to,
                      input bit gapchk);
    int  w;
    bit  ok;
    int  tc;
    exp_q.push_back({2'(c), exp_to, 9'(exp_data)});
    wait_trig(c, w, ok, tc);
    if (ok) begin
      check("trig_width", w, TRIG);
      if (gapchk) check("holdoff_gap", tc - last_valid_cyc, REPORT_TO_TRIG);
      if (len > 0) begin
        fork
          echo_pulse(c, len);
        join_none
      end
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int  w;
    bit  ok;
    int  tc;
    resetn = 1'b0;
    enable = 1'b0;
    echo   = '0;
    repeat (3) @(negedge clock);
    check("reset_trig", int'(trig), 0);
    check("reset_valid", int'(dist_valid), 0);
    check("reset_data", int'(dist_data), 0);
    check("reset_chan", int'(dist_chan), 0);
    check("reset_timeout", int'(dist_timeout), 0);
    check("reset_busy", int'(busy), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_busy_disabled", int'(busy), 0);
    enable = 1'b1;

    // 57 high cycles -> 5 cm; then four more pings of 25 -> 2 cm, chans 1,2,3,0
    ping(0, 57, 5, 1'b0, 1'b0);
    ping(1, 25, 2, 1'b0, 1'b1);
    ping(2, 25, 2, 1'b0, 1'b1);
    ping(3, 25, 2, 1'b0, 1'b1);
    ping(0, 25, 2, 1'b0, 1'b1);

    // No echo -> WAIT_RISE timeout; echo stuck high -> MEASURE timeout
    ping(1, 0, 9'h1FF, 1'b1, 1'b1);
    ping(2, 300, 9'h1FF, 1'b1, 1'b1);
    ping(3, 33, 3, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a measurement on chan 0
    wait_trig(0, w, ok, tc);
    repeat (2) @(negedge clock);
    echo[0] = 1'b1;
    repeat (30) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_trig", int'(trig), 0);
    check("async_reset_busy", int'(busy), 0);
    echo[0] = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_clears_data", int'(dist_data), 0);
    resetn = 1'b1;

    // Restart at chan 0, then disable mid-measure on chan 2 (35 high -> 3 cm)
    ping(0, 44, 4, 1'b0, 1'b0);
    ping(1, 19, 1, 1'b0, 1'b1);
    exp_q.push_back({2'd2, 1'b0, 9'd3});
    wait_trig(2, w, ok, tc);
    check("trig_width_chan2", w, TRIG);
    repeat (2) @(negedge clock);
    echo[2] = 1'b1;
    repeat (10) @(negedge clock);
    enable = 1'b0;
    repeat (25) @(negedge clock);
    echo[2] = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    check("idle_after_disable", int'(busy), 0);
    check("chan2_reported", exp_q.size(), 0);
    repeat (10) @(negedge clock);
    check("idle_no_trig", int'(trig), 0);
    check("idle_stays_idle", int'(busy), 0);

    // Re-enable: next trig must be on chan 3; leave it to time out
    exp_q.push_back({2'd3, 1'b1, ALL1});
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (trig != '0) break;
    end
    check("next_trig_chan3", int'(trig), 8);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) break;
    end
    check("queue_drained", exp_q.size(), 0);
    enable = 1'b0;
    repeat (5) @(negedge clock);
    check("trig_onehot", onehot_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
